// File: rtl/delay_line_pkg.sv
// Shared helpers for variable-latency delay blocks.
// Delay clamping, delay-counter width and lane offset arithmetic.
package delay_line_pkg;

    // Width needed to hold a delay value in 0..max_delay.
    function automatic int dly_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // A delay of 0 behaves as 1. Anything above max_delay saturates to max_delay.
    function automatic int clamp_delay(input int sel, input int max_delay);
        if (sel < 1) begin
            return 1;
        end
        if (sel > max_delay) begin
            return max_delay;
        end
        return sel;
    endfunction

    // LSB position of lane k in a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// DEPTH:1 selector of {valid, data} stages, indexed by tap_i (0-based).
// Purely combinational, no latency. No flow control: it follows its inputs.
module delay_tap_mux #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int SW    = 5
) (
    input  logic [DEPTH-1:0]         stage_vld_i,
    input  logic [DEPTH-1:0][DW-1:0] stage_dat_i,
    input  logic [SW-1:0]            tap_i,
    output logic                     tap_vld_o,
    output logic [DW-1:0]            tap_dat_o
);

    always_comb begin
        tap_vld_o = 1'b0;
        tap_dat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(tap_i) == i) begin
                tap_vld_o = stage_vld_i[i];
                tap_dat_o = stage_dat_i[i];
            end
        end
    end

endmodule

// File: rtl/delay_line_var.sv
// Multi-channel delay line with runtime delay 1..MAX_DELAY, stall and valid clearing.
// Latency is D enabled edges. en=0 freezes the stages. DELAY_LINE_STATUS_EN adds the occupancy and primed outputs.
module delay_line_var
    import delay_line_pkg::*;
#(
    parameter  int SIG_DATA_WIDTH = 8,
    parameter  int CHANNELS       = 4,
    parameter  int MAX_DELAY      = 16,
    localparam int DW             = CHANNELS * SIG_DATA_WIDTH,
    localparam int SW             = dly_width(MAX_DELAY)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [SW-1:0] delay_sel,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid_out,
    output logic [DW-1:0] data_out,
    output logic [SW-1:0] dly_active
`ifdef DELAY_LINE_STATUS_EN
    ,
    output logic [SW-1:0] occupancy,
    output logic          primed
`endif
);

    logic [MAX_DELAY-1:0]         vld_q, vld_d;
    logic [MAX_DELAY-1:0][DW-1:0] dat_q, dat_d;
    logic [SW-1:0]                dly_q, dly_d;
    logic [SW-1:0]                sel_clamped;
    logic                         clr;

    assign sel_clamped = SW'(clamp_delay(int'(delay_sel), MAX_DELAY));
    assign dly_d       = sel_clamped;
    // A delay change invalidates everything in flight: old samples would otherwise emerge at the wrong alignment.
    assign clr         = flush || (sel_clamped != dly_q);

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (en) begin
            vld_d = {vld_q[MAX_DELAY-2:0], valid_in};
            dat_d = {dat_q[MAX_DELAY-2:0], data_in};
        end
        if (clr) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
            dly_q <= SW'(1);
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            dly_q <= dly_d;
        end
    end

    delay_tap_mux #(
        .DW    (DW),
        .DEPTH (MAX_DELAY),
        .SW    (SW)
    ) u_tap (
        .stage_vld_i (vld_q),
        .stage_dat_i (dat_q),
        .tap_i       (dly_q - SW'(1)),
        .tap_vld_o   (valid_out),
        .tap_dat_o   (data_out)
    );

    assign dly_active = dly_q;

`ifdef DELAY_LINE_STATUS_EN
    logic [SW-1:0] occ_q, occ_d;

    // Counted from next-state values so that occupancy stays aligned with the stages it describes.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if ((i < int'(dly_d)) && vld_d[i]) begin
                occ_d = occ_d + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign primed    = (occ_q == dly_q);
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Randomised and directed stimulus for delay_line_var, checked against an edge-indexed reference model.
module tb_delay_line_var;

    localparam int MD = 16;
    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          flush;
    logic [SW-1:0] delay_sel;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [SW-1:0] dly_active;
`ifdef DELAY_LINE_STATUS_EN
    logic [SW-1:0] occupancy;
    logic          primed;
`endif

    delay_line_var #(
        .SIG_DATA_WIDTH (8),
        .CHANNELS       (4),
        .MAX_DELAY      (MD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .delay_sel  (delay_sel),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .dly_active (dly_active)
`ifdef DELAY_LINE_STATUS_EN
        ,
        .occupancy  (occupancy),
        .primed     (primed)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state. Samples are indexed by the enabled edge that accepted them (1-based since reset).
    // A sample is live when its valid_in was set and no clear happened at or after its acceptance.
    int          m_n;
    int          m_clr;
    int          m_dly;
    logic [31:0] m_dat [0:8191];
    bit          m_vin [0:8191];
    bit          saw55;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_ref(input int s);
        if (s == 0) return 1;
        if (s > MD) return MD;
        return s;
    endfunction

    task automatic model_reset();
        m_n   = 0;
        m_clr = 0;
        m_dly = 1;
    endtask

    task automatic model_edge();
        int  nd;
        bit  c;
        nd = clamp_ref(int'(delay_sel));
        c  = flush || (nd != m_dly);
        if (en) begin
            m_n++;
            m_dat[m_n] = data_in;
            m_vin[m_n] = valid_in;
        end
        if (c) m_clr = m_n;
        m_dly = nd;
    endtask

    task automatic check_outputs();
        int          k;
        logic        ev;
        logic [31:0] ed;
        k  = m_n - m_dly + 1;
        ev = 1'b0;
        ed = '0;
        if (k >= 1) begin
            ed = m_dat[k];
            ev = m_vin[k] && (k > m_clr);
        end
        check("valid_out", {31'd0, valid_out}, {31'd0, ev});
        check("data_out", data_out, ed);
        check("dly_active", {27'd0, dly_active}, m_dly);
        if (valid_out && data_out == 32'h5555_5555) saw55 = 1'b1;
`ifdef DELAY_LINE_STATUS_EN
        begin
            int occ;
            occ = 0;
            for (int j = (k < 1) ? 1 : k; j <= m_n; j++) begin
                if (m_vin[j] && j > m_clr) occ++;
            end
            check("occupancy", {27'd0, occupancy}, occ);
            check("primed", {31'd0, primed}, {31'd0, occ == m_dly});
        end
`endif
    endtask

    task automatic cycle(input bit e, input bit f, input int sel, input bit v, input logic [31:0] d);
        en        = e;
        flush     = f;
        delay_sel = sel[SW-1:0];
        valid_in  = v;
        data_in   = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Called from just after a checked edge: reset lands mid-cycle and must act without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_dly", {27'd0, dly_active}, 32'd1);
`ifdef DELAY_LINE_STATUS_EN
        check("rst_occ", {27'd0, occupancy}, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         cur_sel;
        reset     = 1'b1;
        en        = 1'b0;
        flush     = 1'b0;
        valid_in  = 1'b0;
        delay_sel = '0;
        data_in   = '0;
        saw55     = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Delay 6: stream 1,2,3...
        cycle(1, 0, 6, 0, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            b = 8'(i);
            cycle(1, 0, 6, 1, {4{b}});
        end

        // Clamp extremes.
        for (int i = 0; i < 8; i++) begin
            b = 8'(i + 40);
            cycle(1, 0, 0, 1, {4{b}});
        end
        for (int i = 0; i < 24; i++) begin
            b = 8'(i + 60);
            cycle(1, 0, 31, 1, {4{b}});
        end

        // Delay 4 with a 3-cycle stall mid-stream.
        cycle(1, 0, 4, 0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'hA0 + i);
            if (i == 6) begin
                for (int s = 0; s < 3; s++) cycle(0, 0, 4, 1, 32'hDEAD_BEEF);
            end
            cycle(1, 0, 4, 1, {4{b}});
        end

        // Delay 8 fully loaded, then drop to 3.
        cycle(1, 0, 8, 0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'hC0 + i);
            cycle(1, 0, 8, 1, {4{b}});
        end
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'hD0 + i);
            cycle(1, 0, 3, 1, {4{b}});
        end

        // Flush coinciding with a valid 0x55 sample.
        for (int i = 0; i < 4; i++) cycle(1, 0, 5, 1, 32'h0101_0101 * (i + 1));
        cycle(1, 1, 5, 1, 32'h5555_5555);
        for (int i = 0; i < 8; i++) cycle(1, 0, 5, 1, 32'h1111_0000 + i);
        check("flush_55_seen", {31'd0, saw55}, 32'd0);

        // Random traffic.
        cur_sel = 5;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 99) < 5) cur_sel = $urandom_range(0, 31);
            cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3, cur_sel,
                  $urandom_range(0, 1) == 1, $urandom);
            if (i == 600) async_reset();
        end

        // Reset in the middle of a steady delay-5 stream.
        for (int i = 0; i < 7; i++) cycle(1, 0, 5, 1, 32'h7700_0000 + i);
        async_reset();
        for (int i = 0; i < 12; i++) cycle(1, 0, 5, 1, 32'h8800_0000 + i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
# delay_line_var

Runtime-programmable, multi-channel delay line with stall and valid tracking. It is the parametrised successor to the fixed 6-cycle single-bit delay cells. It aligns control and data sideband signals across CNN pipeline stages whose latency depends on layer configuration. It sits between the layer controller and the convolution/pooling datapaths. It honours pipeline stalls and never presents stale data as valid after a reconfiguration.

## Interface
- SIG_DATA_WIDTH, 8: bits per channel
- CHANNELS, 4: parallel lanes sharing one valid/enable
- MAX_DELAY, 16: maximum delay in cycles, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance enable; 0 = stall (hold all stages)
- flush  in  1  synchronous clear of all valid bits
- delay_sel  in  $clog2(MAX_DELAY+1)  requested delay D
- valid_in  in  1  input sample qualifier
- data_in  in  CHANNELS*SIG_DATA_WIDTH  lane k at bits [k*W +: W]
- valid_out  out  1  output qualifier
- data_out  out  CHANNELS*SIG_DATA_WIDTH  delayed data
- dly_active  out  $clog2(MAX_DELAY+1)  delay currently in force (dly_q)

## Operation
- Storage: MAX_DELAY stages, each CHANNELS*W data bits plus one valid bit. Stage 0 is the input stage.
- Clamping: delay_sel is clamped to the range 1..MAX_DELAY. A value of 0 is treated as 1; values above MAX_DELAY become MAX_DELAY.
- Normal edge (en=1, no flush, no reconfig): stage[0] ← {valid_in, data_in}, and stage[i] ← stage[i-1].
- Stall (en=0): data and valid hold. dly_q and flush handling still apply.
- Output: {valid_out, data_out} = stage[dly_q-1]. Outputs are register-driven only and have no combinational path from the inputs.
- Reconfig: occurs when clamp(delay_sel) ≠ dly_q at an edge. At that edge:
  - dly_q ← clamp(delay_sel);
  - all valid bits are cleared, and valid_in on that edge is discarded;
  - data registers shift if en=1.
- Flush: all valid bits are cleared at that edge and valid_in is discarded. Data shifts if en=1; dly_q is unaffected.
- Simultaneous flush and reconfig: both apply, with the same effect as either alone plus the dly_q update.
- Priority: reset > flush/reconfig > en shift.

## Timing
- Reset: all data 0, all valid 0, dly_q = 1. Therefore valid_out = 0, data_out = 0, dly_active = 1.
- Latency: a sample accepted at enabled edge e appears on data_out immediately after the D-th enabled edge counted from e inclusive. D=1 means visible one cycle after acceptance; D=6 matches the legacy 6-cycle cell.
- Stall cycles add no latency to counting; they only delay the wall clock.
- After a reconfig at edge r, the first valid_out can be no earlier than D enabled edges after r.
- Reset asserted mid-stream takes effect asynchronously. The first post-reset valid sample needs the full D enabled edges.
- Throughput: one sample per enabled cycle, with no bubbles.

## Configuration
- DELAY_LINE_STATUS_EN defined adds output `occupancy`, width $clog2(MAX_DELAY+1).
  - It is a registered count of set valid bits in stages 0..dly_q-1.
  - It is updated on the same edge as the stages, and is 0 after reset, flush or reconfig.
  - Adds output `primed`, equal to (occupancy == dly_q).
- Undefined: both ports are absent and no counting logic is generated. Behaviour is otherwise identical.

## Structure
- Package delay_line_pkg:
  - function clamp_delay(sel, max);
  - localparam helper for delay width ($clog2(MAX_DELAY+1));
  - lane slice macro-free indexing function.
- One sub-module, delay_tap_mux. It is a parametrised MAX_DELAY:1 selector of {valid, data} stages indexed by dly_q-1. It is reused by other variable-latency blocks.

## Test plan
- Reset, then MAX_DELAY=16, delay_sel=6, en=1, streaming 1,2,3…: sample 1 appears on the 6th enabled edge after acceptance, and valid_out stays 0 for the first 5 cycles.
- delay_sel=0 drives dly_active=1 with 1-cycle latency. delay_sel=31 with MAX_DELAY=16 drives dly_active=16 with 16-cycle latency.
- Delay 4, streaming 0xA0.., en low for 3 cycles mid-stream: the output sequence is unchanged with no duplicates or drops, and is shifted by exactly 3 cycles.
- Delay 8 with 8 valid samples in flight, then delay_sel changes to 3: valid_out = 0 for 3 enabled edges. The first valid output is the sample accepted on the edge after the reconfig.
- flush pulse coinciding with valid_in=1 and data 0x55: 0x55 never appears with valid_out=1, and dly_active is unchanged.
- With DELAY_LINE_STATUS_EN and delay 5, feed 5 valid samples: occupancy counts 1..5 and primed asserts on the 5th edge. Async reset asserted mid-stream clears occupancy, valid_out and data_out to 0 immediately.
